// File: rtl/bypass_sb_pkg.sv
// Shared types and constants for the bypass scoreboard (bypass_sb).
// Optional performance counters in the top are enabled by defining BYPASS_SB_PERF_EN.
package bypass_sb_pkg;

    localparam int unsigned REG_W       = 5;
    // Stored width of the ready-stage index; covers up to 16 tracked stages.
    localparam int unsigned RDY_W       = 4;

    localparam int unsigned DEF_ISSUE_W = 2;
    localparam int unsigned DEF_NSRC    = 2;
    localparam int unsigned DEF_NSTAGE  = 3;
    localparam int unsigned DEF_DATA_W  = 32;

    localparam int unsigned STG_E       = 0;
    localparam int unsigned STG_M1      = 1;
    localparam int unsigned STG_M2      = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rdst;
        logic [RDY_W-1:0] rdy;
    } sb_entry_t;

    function automatic int unsigned rdy_port_w(input int unsigned nstage);
        return (nstage > 1) ? $clog2(nstage) : 1;
    endfunction

endpackage

// File: rtl/bypass_sb_lookup.sv
// One source operand searched against every in-flight entry; youngest match wins
// (stage 0 first, higher lane first within a stage).
module bypass_sb_lookup
    import bypass_sb_pkg::*;
#(
    parameter int unsigned ISSUE_W = DEF_ISSUE_W,
    parameter int unsigned NSTAGE  = DEF_NSTAGE,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic [REG_W-1:0]                          ra_i,
    input  sb_entry_t [NSTAGE-1:0][ISSUE_W-1:0]       ent_i,
    input  logic [NSTAGE-1:0][ISSUE_W-1:0][DATA_W-1:0] data_i,
    output logic                                      hit_o,
    output logic                                      hazard_o,
    output logic [DATA_W-1:0]                         data_o
);

    logic found;

    always_comb begin
        hit_o    = 1'b0;
        hazard_o = 1'b0;
        data_o   = '0;
        found    = 1'b0;
        for (int s = 0; s < int'(NSTAGE); s++) begin
            for (int l = int'(ISSUE_W) - 1; l >= 0; l--) begin
                if (!found && ent_i[s][l].valid && (ent_i[s][l].rdst == ra_i) &&
                    (ra_i != '0)) begin
                    found = 1'b1;
                    // Result exists once the entry has reached its ready stage.
                    if (ent_i[s][l].rdy <= RDY_W'(s)) begin
                        hit_o  = 1'b1;
                        data_o = data_i[s][l];
                    end else begin
                        hazard_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bypass_sb.sv
// Bypass scoreboard: shadow pipeline of in-flight writers, operand forwarding and issue gating.
// Defining BYPASS_SB_PERF_EN adds saturating perf_stall_o / perf_fwd_o counters.
module bypass_sb
    import bypass_sb_pkg::*;
#(
    parameter int unsigned ISSUE_W = DEF_ISSUE_W,
    parameter int unsigned NSRC    = DEF_NSRC,
    parameter int unsigned NSTAGE  = DEF_NSTAGE,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    localparam int unsigned RW     = rdy_port_w(NSTAGE)
) (
    input  logic                                      clk_i,
    input  logic                                      resetn_i,
    input  logic [ISSUE_W-1:0]                        iss_valid_i,
    input  logic [ISSUE_W-1:0][NSRC-1:0][REG_W-1:0]   iss_ra_i,
    input  logic [ISSUE_W-1:0][REG_W-1:0]             iss_rdst_i,
    input  logic [ISSUE_W-1:0]                        iss_regwrite_i,
    input  logic [ISSUE_W-1:0][RW-1:0]                iss_rdy_i,
    input  logic [ISSUE_W-1:0]                        iss_fire_i,
    input  logic                                      adv_i,
    input  logic                                      flush_i,
    input  logic [NSTAGE-1:0][ISSUE_W-1:0][DATA_W-1:0] stg_data_i,
    output logic [ISSUE_W-1:0]                        iss_ok_o,
    output logic [ISSUE_W-1:0][NSRC-1:0]              fwd_hit_o,
    output logic [ISSUE_W-1:0][NSRC-1:0][DATA_W-1:0]  fwd_data_o
`ifdef BYPASS_SB_PERF_EN
    ,
    output logic [31:0]                               perf_stall_o,
    output logic [31:0]                               perf_fwd_o
`endif
);

    sb_entry_t [NSTAGE-1:0][ISSUE_W-1:0] ent_q, ent_d;
    logic [ISSUE_W-1:0][NSRC-1:0]        haz;
    logic [ISSUE_W-1:0]                  intra;
    logic                                ok_chain;

    always_comb begin
        ent_d = ent_q;
        if (flush_i) begin
            ent_d = '0;
        end else if (adv_i) begin
            for (int s = int'(NSTAGE) - 1; s > 0; s--) begin
                ent_d[s] = ent_q[s-1];
            end
            for (int k = 0; k < int'(ISSUE_W); k++) begin
                ent_d[STG_E][k].valid = iss_fire_i[k] & iss_regwrite_i[k] &
                                        (iss_rdst_i[k] != '0);
                ent_d[STG_E][k].rdst  = iss_rdst_i[k];
                ent_d[STG_E][k].rdy   = RDY_W'(iss_rdy_i[k]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
        for (genvar j = 0; j < NSRC; j++) begin : g_src
            bypass_sb_lookup #(
                .ISSUE_W (ISSUE_W),
                .NSTAGE  (NSTAGE),
                .DATA_W  (DATA_W)
            ) u_lookup (
                .ra_i     (iss_ra_i[k][j]),
                .ent_i    (ent_q),
                .data_i   (stg_data_i),
                .hit_o    (fwd_hit_o[k][j]),
                .hazard_o (haz[k][j]),
                .data_o   (fwd_data_o[k][j])
            );
        end
    end

    // An older valid writer in the same bundle blocks any younger reader of its rdst.
    always_comb begin
        intra = '0;
        for (int i = 1; i < int'(ISSUE_W); i++) begin
            for (int k = 0; k < i; k++) begin
                for (int j = 0; j < int'(NSRC); j++) begin
                    if (iss_valid_i[k] && iss_regwrite_i[k] && (iss_rdst_i[k] != '0) &&
                        (iss_ra_i[i][j] == iss_rdst_i[k])) begin
                        intra[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        iss_ok_o = '0;
        ok_chain = 1'b1;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            ok_chain    = ok_chain & iss_valid_i[i] & ~(|haz[i]) & ~intra[i];
            iss_ok_o[i] = ok_chain;
        end
    end

`ifdef BYPASS_SB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_fwd_q, perf_fwd_d;
    logic [31:0] fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_inc = '0;
        for (int k = 0; k < int'(ISSUE_W); k++) begin
            for (int j = 0; j < int'(NSRC); j++) begin
                if (iss_fire_i[k] && fwd_hit_o[k][j]) begin
                    fwd_inc = fwd_inc + 32'd1;
                end
            end
        end
        fwd_sum    = {1'b0, perf_fwd_q} + {1'b0, fwd_inc};
        perf_fwd_d = fwd_sum[32] ? '1 : fwd_sum[31:0];

        perf_stall_d = perf_stall_q;
        if (iss_valid_i[0] && !iss_ok_o[0] && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_fwd_q   <= perf_fwd_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_fwd_o   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_bypass_sb.sv
// Self-checking bench for bypass_sb: directed vector table, hand sequences, random vs model.
module tb_bypass_sb;

    localparam int NST = 3;

    logic                   clk = 1'b0;
    logic                   resetn, flush, adv;
    logic [1:0]             valid, rw, fire;
    logic [1:0][1:0][4:0]   ra;
    logic [1:0][4:0]        rdst;
    logic [1:0][1:0]        rdy;
    logic [2:0][1:0][31:0]  sd;
    logic [1:0]             ok;
    logic [1:0][1:0]        hit;
    logic [1:0][1:0][31:0]  fdata;
`ifdef BYPASS_SB_PERF_EN
    logic [31:0]            perf_stall, perf_fwd;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bypass_sb u_dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .iss_valid_i    (valid),
        .iss_ra_i       (ra),
        .iss_rdst_i     (rdst),
        .iss_regwrite_i (rw),
        .iss_rdy_i      (rdy),
        .iss_fire_i     (fire),
        .adv_i          (adv),
        .flush_i        (flush),
        .stg_data_i     (sd),
        .iss_ok_o       (ok),
        .fwd_hit_o      (hit),
        .fwd_data_o     (fdata)
`ifdef BYPASS_SB_PERF_EN
        ,
        .perf_stall_o   (perf_stall),
        .perf_fwd_o     (perf_fwd)
`endif
    );

    typedef struct {
        logic                  resetn, flush, adv;
        logic [1:0]            valid, rw, fire;
        logic [1:0][1:0][4:0]  ra;
        logic [1:0][4:0]       rdst;
        logic [1:0][1:0]       rdy;
        logic [2:0][1:0][31:0] sd;
        logic [1:0]            eok;
        logic [3:0]            ehit;
        logic [1:0][1:0][31:0] edata;
    } vec_t;

    // In-flight writer as the specification describes it: where it is and who wrote it.
    typedef struct {
        int stage;
        int lane;
        int rdst;
        int rdy;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rs, fl, ad, input logic [1:0] va,
                                 input int a00, a01, a10, a11, d0, d1,
                                 input logic [1:0] w, input int y0, y1, input logic [1:0] fi,
                                 input logic [31:0] s00, s01, input logic [1:0] eok,
                                 input logic [3:0] eh, input logic [31:0] e00, e01, e10, e11);
        vec_t v;
        v.resetn = rs; v.flush = fl; v.adv = ad; v.valid = va; v.rw = w; v.fire = fi;
        v.ra[0][0] = 5'(a00); v.ra[0][1] = 5'(a01); v.ra[1][0] = 5'(a10); v.ra[1][1] = 5'(a11);
        v.rdst[0] = 5'(d0); v.rdst[1] = 5'(d1);
        v.rdy[0] = 2'(y0); v.rdy[1] = 2'(y1);
        v.sd[0][0] = s00; v.sd[0][1] = s01;
        v.sd[1][0] = 32'h1110; v.sd[1][1] = 32'h1111;
        v.sd[2][0] = 32'h2220; v.sd[2][1] = 32'h2221;
        v.eok = eok; v.ehit = eh;
        v.edata[0][0] = e00; v.edata[0][1] = e01; v.edata[1][0] = e10; v.edata[1][1] = e11;
        return v;
    endfunction

    task automatic model_expect(output logic [1:0] eok, output logic [1:0][1:0] ehit,
                                output logic [1:0][1:0][31:0] edata);
        logic [1:0] blocked;
        logic       chain;
        blocked = '0;
        ehit    = '0;
        edata   = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int bs, bl, bi;
                bs = 99; bl = -1; bi = -1;
                foreach (mq[n]) begin
                    if (ra[i][j] != 0 && mq[n].rdst == int'(ra[i][j]) &&
                        (mq[n].stage < bs || (mq[n].stage == bs && mq[n].lane > bl))) begin
                        bs = mq[n].stage; bl = mq[n].lane; bi = n;
                    end
                end
                if (bi >= 0) begin
                    if (mq[bi].rdy <= bs) begin
                        ehit[i][j]  = 1'b1;
                        edata[i][j] = sd[bs][bl];
                    end else begin
                        blocked[i] = 1'b1;
                    end
                end
                for (int k = 0; k < i; k++) begin
                    if (valid[k] && rw[k] && rdst[k] != 0 && ra[i][j] == rdst[k])
                        blocked[i] = 1'b1;
                end
            end
        end
        chain = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chain  = chain && valid[i] && !blocked[i];
            eok[i] = chain;
        end
    endtask

    task automatic model_step();
        ent_t nq[$];
        if (!resetn || flush) begin
            mq.delete();
        end else if (adv) begin
            foreach (mq[n]) begin
                if (mq[n].stage + 1 < NST) begin
                    ent_t e;
                    e = mq[n];
                    e.stage++;
                    nq.push_back(e);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (fire[k] && rw[k] && rdst[k] != 0)
                    nq.push_back('{0, k, int'(rdst[k]), int'(rdy[k])});
            end
            mq = nq;
        end
    endtask

    task automatic check_model(input string tag);
        logic [1:0]            eok;
        logic [1:0][1:0]       ehit;
        logic [1:0][1:0][31:0] edata;
        model_expect(eok, ehit, edata);
        chk({tag, ".iss_ok"}, 128'(ok), 128'(eok));
        chk({tag, ".fwd_hit"}, 128'(hit), 128'(ehit));
        chk({tag, ".fwd_data"}, 128'(fdata), 128'(edata));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        resetn = 1'b1; flush = 1'b0; adv = 1'b0; valid = '0; rw = '0; fire = '0;
        ra = '0; rdst = '0; rdy = '0; sd = '0;
    endtask

    vec_t vt[19];

    initial begin
        vt[0]  = mkv(1, 0, 0, 2'b11, 0, 0, 9, 0, 9, 0, 2'b01, 0, 0, 2'b00, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);
        vt[1]  = mkv(1, 0, 1, 2'b01, 0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 2'b01, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);
        vt[2]  = mkv(1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'h1234, 0,
                     2'b01, 4'b0001, 32'h1234, 0, 0, 0);
        vt[3]  = mkv(1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b00, 4'b0000, 0, 0, 0, 0);
        vt[4]  = mkv(1, 0, 1, 2'b01, 0, 0, 0, 0, 7, 0, 2'b01, 2, 0, 2'b01, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);
        vt[5]  = mkv(1, 0, 1, 2'b01, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b00, 4'b0000, 0, 0, 0, 0);
        vt[6]  = mkv(1, 0, 1, 2'b01, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b00, 4'b0000, 0, 0, 0, 0);
        vt[7]  = mkv(1, 0, 1, 2'b01, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b01, 4'b0001, 32'h2220, 0, 0, 0);
        vt[8]  = mkv(1, 0, 1, 2'b11, 0, 0, 0, 0, 3, 3, 2'b11, 0, 0, 2'b11, 0, 0,
                     2'b11, 4'b0000, 0, 0, 0, 0);
        vt[9]  = mkv(1, 0, 1, 2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 32'hA, 32'hB,
                     2'b01, 4'b0001, 32'hB, 0, 0, 0);
        vt[10] = mkv(1, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b11, 0, 0,
                     2'b11, 4'b0000, 0, 0, 0, 0);
        vt[11] = mkv(1, 0, 0, 2'b10, 0, 0, 0, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b00, 4'b1000, 0, 0, 0, 32'h2221);
        vt[12] = mkv(1, 0, 1, 2'b01, 0, 0, 0, 0, 4, 0, 2'b01, 2, 0, 2'b01, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);
        vt[13] = mkv(1, 1, 1, 2'b01, 4, 0, 0, 0, 4, 0, 2'b01, 2, 0, 2'b01, 0, 0,
                     2'b00, 4'b0000, 0, 0, 0, 0);
        vt[14] = mkv(1, 0, 0, 2'b01, 4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);
        for (int r = 15; r < 18; r++)
            vt[r] = mkv(1, 0, 0, 2'b01, 4, 6, 0, 0, 6, 0, 2'b01, 0, 0, 2'b01, 0, 0,
                        2'b01, 4'b0000, 0, 0, 0, 0);
        vt[18] = mkv(1, 0, 0, 2'b01, 6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0,
                     2'b01, 4'b0000, 0, 0, 0, 0);

        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();

        for (int r = 0; r < 19; r++) begin
            resetn = vt[r].resetn; flush = vt[r].flush; adv = vt[r].adv;
            valid = vt[r].valid; rw = vt[r].rw; fire = vt[r].fire;
            ra = vt[r].ra; rdst = vt[r].rdst; rdy = vt[r].rdy; sd = vt[r].sd;
            #1;
            chk($sformatf("vec%0d.iss_ok", r), 128'(ok), 128'(vt[r].eok));
            chk($sformatf("vec%0d.fwd_hit", r), 128'(hit), 128'(vt[r].ehit));
            chk($sformatf("vec%0d.fwd_data", r), 128'(fdata), 128'(vt[r].edata));
            tick();
        end

        // Fill every stage with forwardable writers, then reset mid-stream.
        idle_inputs();
        sd[0][0] = 32'hE0; sd[0][1] = 32'hE1; sd[1][0] = 32'hA0;
        sd[1][1] = 32'hA1; sd[2][0] = 32'hB0; sd[2][1] = 32'hB1;
        for (int c = 0; c < 3; c++) begin
            valid = 2'b11; rw = 2'b11; fire = 2'b11; adv = 1'b1;
            rdst[0] = 5'(10 + c); rdst[1] = 5'(20 + c);
            tick();
        end
        valid = 2'b11; rw = 2'b00; fire = 2'b00; adv = 1'b0;
        ra[0][0] = 5'd10; ra[0][1] = 5'd21; ra[1][0] = 5'd12; ra[1][1] = 5'd22;
        #1;
        chk("full.fwd_hit", 128'(hit), 128'(4'b1111));
        chk("full.fwd_data", 128'(fdata), {32'hE1, 32'hE0, 32'hA1, 32'hB0});
        check_model("full");
        resetn = 1'b0; adv = 1'b1; fire = 2'b11; rw = 2'b11;
        tick();
        resetn = 1'b1; adv = 1'b0; fire = 2'b00; rw = 2'b00;
        #1;
        chk("post_reset.fwd_hit", 128'(hit), 128'(0));
        chk("post_reset.fwd_data", 128'(fdata), 128'(0));
        chk("post_reset.iss_ok", 128'(ok), 128'(2'b11));
`ifdef BYPASS_SB_PERF_EN
        chk("post_reset.perf_stall", 128'(perf_stall), 128'(0));
        chk("post_reset.perf_fwd", 128'(perf_fwd), 128'(0));
`endif
        tick();

        for (int n = 0; n < 3000; n++) begin
            logic [1:0]            eok;
            logic [1:0][1:0]       ehit;
            logic [1:0][1:0][31:0] edata;
            resetn = ($urandom_range(0, 99) != 0);
            flush  = ($urandom_range(0, 19) == 0);
            adv    = ($urandom_range(0, 3) != 0);
            valid  = 2'($urandom);
            rw     = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                rdst[k] = 5'($urandom_range(0, 7));
                rdy[k]  = 2'($urandom_range(0, 2));
                for (int j = 0; j < 2; j++) ra[k][j] = 5'($urandom_range(0, 7));
            end
            for (int s = 0; s < 3; s++)
                for (int k = 0; k < 2; k++) sd[s][k] = $urandom;
            model_expect(eok, ehit, edata);
            fire = ($urandom_range(0, 15) == 0) ? 2'($urandom) : (eok & 2'($urandom));
            #1;
            check_model($sformatf("rand%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
